// File: rtl/pipe_defs.sv
// pipe_defs: shared bus layouts, field offsets and one-hot ALU op indices for the pipeline
package pipe_defs;

    localparam int ALU_OP_W = 12;
    localparam int DS2ES_W  = 148;
    localparam int ES2MS_W  = 71;

    localparam int DS_PC_LSB   = 0;
    localparam int DS_RFM_BIT  = 32;
    localparam int DS_MWE_BIT  = 33;
    localparam int DS_GWE_BIT  = 34;
    localparam int DS_DEST_LSB = 35;
    localparam int DS_RKD_LSB  = 40;
    localparam int DS_SRC2_LSB = 72;
    localparam int DS_SRC1_LSB = 104;
    localparam int DS_OP_LSB   = 136;

    localparam int ES_PC_LSB   = 0;
    localparam int ES_RES_LSB  = 32;
    localparam int ES_DEST_LSB = 64;
    localparam int ES_GWE_BIT  = 69;
    localparam int ES_RFM_BIT  = 70;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic [31:0]         rkd;
        logic [4:0]          dest;
        logic                gr_we;
        logic                mem_we;
        logic                res_from_mem;
        logic [31:0]         pc;
    } ds2es_t;

endpackage

// File: rtl/alu.sv
// alu: one-hot controlled combinational integer ALU (add/sub/compare/logic/shift/lui)
module alu
    import pipe_defs::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         alu_src1,
    input  logic [31:0]         alu_src2,
    output logic [31:0]         alu_result
);

    logic        use_sub;
    logic [31:0] b_eff;
    logic [31:0] sum;
    logic        cout;
    logic        slt;
    logic        sltu;

    // single adder shared by add, sub and both compares; sub/compare use a + ~b + 1
    always_comb begin
        use_sub       = alu_op[OP_SUB] | alu_op[OP_SLT] | alu_op[OP_SLTU];
        b_eff         = use_sub ? ~alu_src2 : alu_src2;
        {cout, sum}   = {1'b0, alu_src1} + {1'b0, b_eff} + {32'd0, use_sub};
        slt           = (alu_src1[31] & ~alu_src2[31]) | (~(alu_src1[31] ^ alu_src2[31]) & sum[31]);
        sltu          = ~cout;
        alu_result    = ({32{alu_op[OP_ADD] | alu_op[OP_SUB]}} & sum)
                      | ({32{alu_op[OP_SLT]}}  & {31'd0, slt})
                      | ({32{alu_op[OP_SLTU]}} & {31'd0, sltu})
                      | ({32{alu_op[OP_AND]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[OP_NOR]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[OP_OR]}}   & (alu_src1 | alu_src2))
                      | ({32{alu_op[OP_XOR]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[OP_SLL]}}  & (alu_src1 << alu_src2[4:0]))
                      | ({32{alu_op[OP_SRL]}}  & (alu_src1 >> alu_src2[4:0]))
                      | ({32{alu_op[OP_SRA]}}  & 32'($signed(alu_src1) >>> alu_src2[4:0]))
                      | ({32{alu_op[OP_LUI]}}  & alu_src2);
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage; EXE_FWD_EN enables the forwarding/hazard bus back to ID
module exe_stage
    import pipe_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ds_to_es_valid,
    input  logic [DS2ES_W-1:0] ds_to_es_bus,
    output logic               es_allowin,
    input  logic               ms_allowin,
    output logic               es_to_ms_valid,
    output logic [ES2MS_W-1:0] es_to_ms_bus,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_we,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata,
    output logic               es_fwd_valid,
    output logic [4:0]         es_fwd_dest,
    output logic [31:0]        es_fwd_data,
    output logic               es_fwd_is_load
);

    logic        es_valid;
    logic        es_ready_go;
    ds2es_t      ds_r;
    logic [31:0] alu_result;

    assign es_ready_go    = 1'b1;
    assign es_allowin     = !es_valid | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid & es_ready_go;

    // stage occupancy: refilled (or emptied) whenever the stage can accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds_to_es_valid;
    end

    // payload register: only captures a real handoff so held/idle data stays put
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ds_r <= '0;
        else if (ds_to_es_valid & es_allowin) ds_r <= ds_to_es_bus;
    end

    alu u_alu (
        .alu_op     (ds_r.alu_op),
        .alu_src1   (ds_r.src1),
        .alu_src2   (ds_r.src2),
        .alu_result (alu_result)
    );

    // gating with ms_allowin keeps a held instruction from re-issuing its access
    assign data_sram_en    = es_valid & (ds_r.mem_we | ds_r.res_from_mem) & ms_allowin;
    assign data_sram_we    = {4{es_valid & ds_r.mem_we & ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = ds_r.rkd;
    assign es_to_ms_bus    = {ds_r.res_from_mem, ds_r.gr_we, ds_r.dest, alu_result, ds_r.pc};

`ifdef EXE_FWD_EN
    assign es_fwd_valid   = es_valid & ds_r.gr_we & (ds_r.dest != 5'd0);
    assign es_fwd_dest    = ds_r.dest;
    assign es_fwd_data    = alu_result;
    assign es_fwd_is_load = es_fwd_valid & ds_r.res_from_mem;
`else
    assign es_fwd_valid   = 1'b0;
    assign es_fwd_dest    = 5'd0;
    assign es_fwd_data    = 32'd0;
    assign es_fwd_is_load = 1'b0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: table-driven scoreboard bench for the execute stage
module tb_exe_stage;
    import pipe_defs::*;

    typedef struct {
        int          op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_we;
        logic        rfm;
        logic [31:0] pc;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [ES2MS_W-1:0] bus;
        logic               en;
        logic [3:0]         we;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic               fv;
        logic [4:0]         fd;
        logic [31:0]        fdata;
        logic               fl;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               ds_to_es_valid;
    logic [DS2ES_W-1:0] ds_to_es_bus;
    logic               es_allowin;
    logic               ms_allowin;
    logic               es_to_ms_valid;
    logic [ES2MS_W-1:0] es_to_ms_bus;
    logic               data_sram_en;
    logic [3:0]         data_sram_we;
    logic [31:0]        data_sram_addr;
    logic [31:0]        data_sram_wdata;
    logic               es_fwd_valid;
    logic [4:0]         es_fwd_dest;
    logic [31:0]        es_fwd_data;
    logic               es_fwd_is_load;

    int   tests = 0;
    int   fails = 0;
    vec_t vt[15];
    vec_t cur;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_allowin      (es_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_fwd_valid    (es_fwd_valid),
        .es_fwd_dest     (es_fwd_dest),
        .es_fwd_data     (es_fwd_data),
        .es_fwd_is_load  (es_fwd_is_load)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int op, logic [31:0] s1, logic [31:0] s2, logic [31:0] rkd,
                                logic [4:0] d, logic g, logic mw, logic rf, logic [31:0] pc, logic [31:0] r);
        vec_t v;
        v.op = op; v.src1 = s1; v.src2 = s2; v.rkd = rkd; v.dest = d;
        v.gr_we = g; v.mem_we = mw; v.rfm = rf; v.pc = pc; v.res = r;
        return v;
    endfunction

    function automatic exp_t mk_exp(vec_t v);
        exp_t x;
        x.bus   = {v.rfm, v.gr_we, v.dest, v.res, v.pc};
        x.en    = v.mem_we | v.rfm;
        x.we    = v.mem_we ? 4'hF : 4'h0;
        x.addr  = v.res;
        x.wdata = v.rkd;
`ifdef EXE_FWD_EN
        x.fv    = v.gr_we && (v.dest != 5'd0);
        x.fd    = v.dest;
        x.fdata = v.res;
        x.fl    = x.fv && v.rfm;
`else
        x.fv    = 1'b0;
        x.fd    = 5'd0;
        x.fdata = 32'd0;
        x.fl    = 1'b0;
`endif
        return x;
    endfunction

    task automatic drive(input vec_t v, input logic valid, input logic ms_in);
        logic [ALU_OP_W-1:0] op1h;
        op1h = ALU_OP_W'(1) << v.op;
        cur = v;
        ds_to_es_valid = valid;
        ms_allowin = ms_in;
        ds_to_es_bus = {op1h, v.src1, v.src2, v.rkd, v.dest, v.gr_we, v.mem_we, v.rfm, v.pc};
    endtask

    // negedge sampling: retire/compare departures, check holds and idle, then record acceptances
    task automatic sample(input bit expect_busy);
        @(negedge clk);
        if (expect_busy) chk("no_bubble", 128'(es_to_ms_valid), 128'(1));
        if (es_to_ms_valid && ms_allowin) begin
            if (q.size() == 0) chk("unexpected_departure", 128'(1), 128'(0));
            else begin
                e = q.pop_front();
                chk("ms_bus", 128'(es_to_ms_bus), 128'(e.bus));
                chk("sram_en", 128'(data_sram_en), 128'(e.en));
                chk("sram_we", 128'(data_sram_we), 128'(e.we));
                if (e.en) chk("sram_addr", 128'(data_sram_addr), 128'(e.addr));
                if (e.en) chk("sram_wdata", 128'(data_sram_wdata), 128'(e.wdata));
                chk("fwd_valid", 128'(es_fwd_valid), 128'(e.fv));
                chk("fwd_is_load", 128'(es_fwd_is_load), 128'(e.fl));
                if (e.fv) chk("fwd_dest", 128'(es_fwd_dest), 128'(e.fd));
                if (e.fv) chk("fwd_data", 128'(es_fwd_data), 128'(e.fdata));
            end
        end else if (es_to_ms_valid) begin
            chk("hold_allowin", 128'(es_allowin), 128'(0));
            chk("hold_en", 128'(data_sram_en), 128'(0));
            chk("hold_we", 128'(data_sram_we), 128'(0));
            if (q.size() != 0) chk("hold_bus", 128'(es_to_ms_bus), 128'(q[0].bus));
        end else begin
            chk("idle_allowin", 128'(es_allowin), 128'(1));
            chk("idle_en", 128'(data_sram_en), 128'(0));
            chk("idle_we", 128'(data_sram_we), 128'(0));
            chk("idle_fwd_valid", 128'(es_fwd_valid), 128'(0));
            chk("idle_fwd_load", 128'(es_fwd_is_load), 128'(0));
            chk("idle_queue_empty", 128'(q.size()), 128'(0));
        end
        if (!reset && ds_to_es_valid && es_allowin) q.push_back(mk_exp(cur));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = mk(OP_ADD,  32'd5,        32'd7,        32'h0,        5'd3, 1, 0, 0, 32'h1c000000, 32'd12);
        vt[1]  = mk(OP_ADD,  32'h1000,     32'h8,        32'hDEADBEEF, 5'd0, 0, 1, 0, 32'h1c000004, 32'h1008);
        vt[2]  = mk(OP_SUB,  32'd10,       32'd3,        32'h0,        5'd5, 1, 0, 0, 32'h1c000008, 32'd7);
        vt[3]  = mk(OP_SLT,  32'hFFFFFFFF, 32'd1,        32'h0,        5'd6, 1, 0, 0, 32'h1c00000c, 32'd1);
        vt[4]  = mk(OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'h0,        5'd7, 1, 0, 0, 32'h1c000010, 32'd0);
        vt[5]  = mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        5'd8, 1, 0, 0, 32'h1c000014, 32'hF000F000);
        vt[6]  = mk(OP_NOR,  32'h0,        32'h0,        32'h0,        5'd9, 1, 0, 0, 32'h1c000018, 32'hFFFFFFFF);
        vt[7]  = mk(OP_OR,   32'h0F,       32'hF0,       32'h0,        5'd10, 1, 0, 0, 32'h1c00001c, 32'hFF);
        vt[8]  = mk(OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h0,        5'd11, 1, 0, 0, 32'h1c000020, 32'h55555555);
        vt[9]  = mk(OP_SLL,  32'd1,        32'd31,       32'h0,        5'd12, 1, 0, 0, 32'h1c000024, 32'h80000000);
        vt[10] = mk(OP_SRL,  32'h80000000, 32'd4,        32'h0,        5'd13, 1, 0, 0, 32'h1c000028, 32'h08000000);
        vt[11] = mk(OP_SRA,  32'h80000000, 32'd4,        32'h0,        5'd14, 1, 0, 0, 32'h1c00002c, 32'hF8000000);
        vt[12] = mk(OP_LUI,  32'h0,        32'h12345000, 32'h0,        5'd15, 1, 0, 0, 32'h1c000030, 32'h12345000);
        vt[13] = mk(OP_ADD,  32'h2000,     32'd4,        32'h0,        5'd4, 1, 0, 1, 32'h1c000034, 32'h2004);
        vt[14] = mk(OP_ADD,  32'd1,        32'd1,        32'h0,        5'd0, 1, 0, 0, 32'h1c000038, 32'd2);
        reset = 1'b1;
        drive(vt[0], 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ms_valid", 128'(es_to_ms_valid), 128'(0));
        chk("rst_allowin", 128'(es_allowin), 128'(1));
        chk("rst_en", 128'(data_sram_en), 128'(0));
        chk("rst_bus", 128'(es_to_ms_bus), 128'(0));
        reset = 1'b0;
        sample(1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            drive(vt[i], 1'b1, 1'b1);
            sample(i > 0);
        end
        tick();
        drive(vt[0], 1'b0, 1'b1);
        sample(1'b1);
        sample(1'b0);
        tick();
        drive(vt[13], 1'b1, 1'b1);
        sample(1'b0);
        tick();
        drive(vt[2], 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sample(1'b1);
            if (k < 2) tick();
        end
        tick();
        ms_allowin = 1'b1;
        sample(1'b1);
        tick();
        ds_to_es_valid = 1'b0;
        sample(1'b1);
        sample(1'b0);
        tick();
        drive(vt[1], 1'b1, 1'b1);
        sample(1'b0);
        tick();
        ds_to_es_valid = 1'b0;
        #2;
        chk("pre_rst_ms_valid", 128'(es_to_ms_valid), 128'(1));
        chk("pre_rst_en", 128'(data_sram_en), 128'(1));
        reset = 1'b1;
        #1;
        chk("async_rst_ms_valid", 128'(es_to_ms_valid), 128'(0));
        chk("async_rst_en", 128'(data_sram_en), 128'(0));
        chk("async_rst_we", 128'(data_sram_we), 128'(0));
        chk("async_rst_fwd", 128'(es_fwd_valid), 128'(0));
        q.delete();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample(1'b0);
            chk("post_rst_ms_valid", 128'(es_to_ms_valid), 128'(0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
